sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Shares one sdram_controller between NUM_PORTS requesters, e.g. a CPU load/store port and a display/DMA port.
- Round-robin arbitration with one transaction in flight at a time.
- Drives the controller's single-cycle-style enable interface: holds enable until `busy` is seen, then waits for completion.
- Returns per-port accept/done pulses and the read data.

Parameters:
- NUM_PORTS, 2, number of requesters (2..4).
- ADDR_W, 25, word address width; matches controller wr_addr/rd_addr.
- DATA_W, 16, data width; matches controller rd_data/wr_data.
- TIMEOUT_CYC, 1024, cycle limit per transaction (used only with SDRAM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  controller clock (100 MHz PLL output).
- rst  in  1  asynchronous, active-high reset.
- p_req  in  NUM_PORTS  per-port request; held until p_ack.
- p_we  in  NUM_PORTS  1 = write, 0 = read; valid with p_req.
- p_addr  in  NUM_PORTS*ADDR_W  packed addresses; port i at [i*ADDR_W +: ADDR_W].
- p_wdata  in  NUM_PORTS*DATA_W  packed write data.
- p_ack  out  NUM_PORTS  1-cycle pulse: request latched; requester may drop or change inputs next cycle.
- p_done  out  NUM_PORTS  1-cycle pulse: transaction finished.
- p_rdata  out  DATA_W  read data; valid in the p_done cycle of a read; holds until the next read completes.
- p_err  out  1  valid with p_done; 1 = timed-out transaction.
- wr_addr  out  ADDR_W  to controller.
- wr_data  out  DATA_W  to controller.
- wr_enable  out  1  to controller.
- rd_addr  out  ADDR_W  to controller.
- rd_enable  out  1  to controller.
- rd_data  in  DATA_W  from controller.
- rd_ready  in  1  from controller; 1-cycle read-data strobe.
- busy  in  1  from controller.

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0; p_ack, p_done, p_err, wr_enable, rd_enable = 0; wr_addr, wr_data, rd_addr, p_rdata = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: grants only when busy==0 and some p_req is high.
  - Winner is the first requesting port scanning from rr_ptr upward, with wrap.
  - Grant cycle: p_ack[winner]=1; latch we/addr/wdata and the winner index; rr_ptr <= winner+1 mod NUM_PORTS; go to ISSUE.
- ISSUE: drive wr_enable (we=1) or rd_enable (we=0) with the latched address/data; all other controller outputs are 0.
  - Stay in ISSUE until the cycle busy==1 is sampled.
  - That cycle: drop the enable and zero the addr/data outputs next edge; go to WAIT.
- WAIT:
  - Write: complete on the first cycle busy==0.
  - Read: complete on the cycle rd_ready==1; latch rd_data into p_rdata that edge.
  - Then go to DONE.
- DONE: p_done[winner]=1 for exactly one cycle; go to IDLE.
- Latency, uncontended write: p_ack at grant cycle G; enable asserted G+1..B, where B is the first cycle busy=1; p_done one cycle after busy falls.
- At most one p_ack and one p_done bit high in any cycle.
- Simultaneous requests: rr_ptr decides. Two ports requesting continuously alternate 0,1,0,1.
- A request withdrawn before p_ack is ignored (no ack, no transaction).
- rd_ready outside WAIT-of-a-read is ignored; p_rdata is unchanged.
- busy already high in IDLE (controller refresh/init) blocks grants; requests wait.
- p_req of the port currently in service is not re-sampled until IDLE.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ISSUE and increments in ISSUE/WAIT.
  - On reaching TIMEOUT_CYC-1: drop enables, go to DONE with p_err=1. p_rdata is not updated for a timed-out read.
  - Counter width is $clog2(TIMEOUT_CYC)+1.
- Undefined: no counter; p_err tied 0; FSM waits indefinitely.

Test Plan:
- Write port0 addr 0x0000000 data 0x3D1A, controller model busy 5 cycles → wr_enable high until busy seen, wr_addr=0, wr_data=0x3D1A; p_done[0] 1 cycle after busy falls; p_err=0.
- Read port1 addr 0x0000000 after the write; model returns rd_ready with 0x3D1A → p_rdata=0x3D1A in the p_done[1] cycle and held afterward.
- Ports 0 and 1 request continuously from reset → grant order 0,1,0,1; never two p_ack bits high in one cycle.
- busy held high 200 cycles after reset (init) while p_req[0]=1 → no p_ack until busy=0, then p_ack[0] the next IDLE cycle.
- Assert rst during WAIT of a read → all outputs 0 immediately; a later rd_ready does not change p_rdata or pulse p_done.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, model never raises busy → enable dropped, p_done[0]=1 with p_err=1 at cycle 16 after ISSUE entry; next request is serviced normally.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Bus bundles for sdram_arbiter: requester side (arb_req_if) and controller side (arb_mem_if).
// Requesters are masters of arb_req_if; the arbiter is master of arb_mem_if.
interface arb_req_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 16
);
    logic [NUM_PORTS-1:0]        p_req;
    logic [NUM_PORTS-1:0]        p_we;
    logic [NUM_PORTS*ADDR_W-1:0] p_addr;
    logic [NUM_PORTS*DATA_W-1:0] p_wdata;
    logic [NUM_PORTS-1:0]        p_ack;
    logic [NUM_PORTS-1:0]        p_done;
    logic [DATA_W-1:0]           p_rdata;
    logic                        p_err;

    modport master (output p_req, p_we, p_addr, p_wdata,
                    input  p_ack, p_done, p_rdata, p_err);
    modport slave  (input  p_req, p_we, p_addr, p_wdata,
                    output p_ack, p_done, p_rdata, p_err);
endinterface

interface arb_mem_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_enable;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_enable;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic              busy;

    modport master (output wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
                    input  rd_data, rd_ready, busy);
    modport slave  (input  wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
                    output rd_data, rd_ready, busy);
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one sdram_controller among NUM_PORTS requesters, one transaction at a time.
// Optional per-transaction timeout with error flag: define SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic      clk,
    input  logic      rst,
    arb_req_if.slave  req,
    arb_mem_if.master mem
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr, winner, pick, pick_next;
    logic              found, grant, finish;
    logic              we_l;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l, rdata_q;
    logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0] wdata_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign addr_arr[g]  = req.p_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req.p_wdata[g*DATA_W +: DATA_W];
    end

    // First requesting port at or after rr_ptr, wrapping around.
    always_comb begin : rr_scan
        int               j;
        logic [IDX_W-1:0] jj;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            jj = IDX_W'(j);
            if (!found && req.p_req[jj]) begin
                found = 1'b1;
                pick  = jj;
            end
        end
        pick_next = (pick == IDX_W'(NUM_PORTS-1)) ? '0 : pick + IDX_W'(1);
    end

    assign grant = (state == IDLE) && !mem.busy && found && !rst;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] cnt;
    logic             err_q, timeout;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   if (mem.busy) state_nxt = WAIT;
            WAIT:    if (we_l ? !mem.busy : mem.rd_ready) begin
                         finish    = 1'b1;
                         state_nxt = DONE;
                     end
            default: state_nxt = IDLE;
        endcase
`ifdef SDRAM_ARB_TIMEOUT_EN
        // A genuine completion in the same cycle wins over the timeout.
        timeout = (state == ISSUE || state == WAIT) && !finish &&
                  (cnt == CNT_W'(TIMEOUT_CYC - 1));
        if (timeout) state_nxt = DONE;
`endif
    end

    always_comb begin
        req.p_ack     = '0;
        req.p_done    = '0;
        mem.wr_enable = 1'b0;
        mem.rd_enable = 1'b0;
        mem.wr_addr   = '0;
        mem.wr_data   = '0;
        mem.rd_addr   = '0;
        if (grant) req.p_ack[pick] = 1'b1;
        if (state == DONE) req.p_done[winner] = 1'b1;
        if (state == ISSUE) begin
            if (we_l) begin
                mem.wr_enable = 1'b1;
                mem.wr_addr   = addr_l;
                mem.wr_data   = wdata_l;
            end else begin
                mem.rd_enable = 1'b1;
                mem.rd_addr   = addr_l;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            winner  <= '0;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            rdata_q <= '0;
        end else begin
            if (grant) begin
                winner  <= pick;
                rr_ptr  <= pick_next;
                we_l    <= req.p_we[pick];
                addr_l  <= addr_arr[pick];
                wdata_l <= wdata_arr[pick];
            end
            if (finish && !we_l) rdata_q <= mem.rd_data;
        end
    end

    assign req.p_rdata = rdata_q;

`ifdef SDRAM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (grant)                              cnt <= '0;
            else if (state == ISSUE || state == WAIT) cnt <= cnt + CNT_W'(1);
            if (grant)        err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end

    assign req.p_err = (state == DONE) && err_q;
`else
    assign req.p_err = 1'b0;
`endif

endmodule
